osc_coef_gen: RTL and testbench
===============================

Name: osc_coef_gen

Overview:
- Control-side producer for the recursive sine oscillator.
- Takes a phase-step request B and an amplitude, and computes the two load words with an iterative CORDIC:
  - init2 = 2cos(B), Q3.29
  - init1 = Amp*sin(B)
- Issues the oscillator's Ready (initial load) or freqchange (retune) strobe and generates its sample-rate Enable tick.
- Sits between the register/command interface and the oscillator.

Parameters:
- ITER, 30, CORDIC micro-rotations, range 16..30.
- CORDIC_K, 652032875, round(2^30/1.6467602581), the x0 start value.

Ports:
- Fg_CLK     in   1   system clock; all logic on rising edge
- RESET      in   1   synchronous, active-high reset
- Start      in   1   one-cycle request; ignored while Busy
- Retune     in   1   sampled with Start: 0 = initial load (Ready), 1 = retune (freqchange)
- Phase      in   32  phase step B; 2^32 = 2π; legal 1..2^30-1
- Amp        in   30  unsigned amplitude; init1 peak = Amp*sin(B)
- Run        in   1   1 = Enable ticks allowed
- SampleDiv  in   16  Enable period in clocks; 0 = Enable never asserted
- init1      out  32  signed sin load word
- init2      out  32  signed 2cos(B) coefficient, Q3.29
- Ready      out  1   one-cycle initial-load strobe
- freqchange out  1   one-cycle retune strobe
- Enable     out  1   one-cycle sample tick
- Busy       out  1   computation in progress
- Error      out  1   one-cycle strobe: illegal Phase, request dropped

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; Enable counter 0.
- FSM states: IDLE -> ROT -> SCALE -> ISSUE -> IDLE.
- IDLE, on Start=1 at edge t:
  - Phase==0 or Phase>=2^30: Error=1 at t+1, stay IDLE, outputs unchanged.
  - Otherwise latch Phase, Amp, Retune; load x=CORDIC_K, y=0, z=Phase (z 33-bit signed); go to ROT; Busy=1 from t+1.
- ROT: one iteration per clock, i = 0..ITER-1.
  - d = +1 if z>=0, else -1.
  - x' = x - d*(y>>>i)
  - y' = y + d*(x>>>i)
  - z' = z - d*ATAN[i]
  - ATAN[i] = round(atan(2^-i)*2^32/(2π)), held in an internal constant table.
  - x and y are 34-bit signed with arithmetic shifts.
  - After ITER cycles go to SCALE.
- SCALE, one cycle:
  - C = x saturated to signed 32 bits.
  - P = y*Amp, unsigned-times-signed, 64-bit.
  - S1 = P>>>30, truncated to 32 bits; fits because |y|<=2^30+margin and Amp<2^30.
- ISSUE, one cycle:
  - init2 <= C, init1 <= S1.
  - Ready=1 if latched Retune=0, else freqchange=1.
  - Busy drops to 0 in the same cycle.
- Latency: Start at edge t gives the strobe and the new init words high during cycle t+ITER+2 (t+32 at ITER=30).
- init1/init2 change only in ISSUE and are held otherwise, because the oscillator may sample them on a later zero-cross after a retune.
- Start while Busy (including the ISSUE cycle) is ignored; no queueing, no Error.
- Accuracy: |init2 - round(2cos(B)*2^29)| <= 64; |init1 - round(Amp*sin(B))| <= 64 + Amp/2^24.
- Enable generator: 16-bit counter, active only when Run=1 and SampleDiv!=0.
  - Counter increments each clock; when counter==SampleDiv-1, Enable=1 and counter wraps to 0.
  - SampleDiv=1 gives Enable on every clock.
  - Run=0 or SampleDiv==0: Enable=0 and counter held at 0.
  - A Ready strobe clears the counter, so the first Enable comes SampleDiv clocks after Ready.
  - freqchange does not touch the counter; sample timing stays phase-continuous.
  - Enable is not masked during Busy; the oscillator gives Ready priority.
- SampleDiv change mid-count: takes effect on the next compare; if counter>=new SampleDiv, counting continues to 0xFFFF, wraps, then recovers.
- RESET mid-computation: aborts, returns to IDLE, all outputs 0, no strobe.
- Ready/freqchange are never asserted together and never for more than one cycle.

Test Plan:
- Reset, then Start, Retune=0, Phase=2^28 (π/8), Amp=2^29 -> Ready at t+32; init2 ≈ 992,008,094 ±64; init1 ≈ 205,451,460 ±96; Busy high for cycles t+1..t+31.
- Phase=2^30-1 (≈π/2), Amp=2^29-1 -> init2 within ±70 of 0; init1 ≈ 536,870,911 ±96.
- Phase=0, then Phase=2^30 -> Error one cycle each; no Busy, no Ready; init words unchanged.
- After the initial load, Start, Retune=1, Phase=2^27; second Start at t+10 -> single freqchange at t+32, no Ready; second Start dropped; init words change only at t+32.
- Run=1, SampleDiv=4 -> Enable every 4th clock; Ready clears the counter (next Enable 4 clocks after Ready); freqchange leaves the cadence intact; SampleDiv=0 -> Enable stays low.
- RESET asserted at t+15 during ROT -> all outputs 0 next cycle, no strobe; a fresh Start completes normally.

Source files
------------

// File: rtl/osc_coef_gen.sv
// Iterative CORDIC producing the recursive oscillator's 2cos(B) and Amp*sin(B) load words, plus its Enable tick.
// Start to Ready/freqchange is ITER+2 clocks; a Start arriving while a computation is in flight is dropped, not queued.
module osc_coef_gen #(
    parameter int          ITER     = 30,
    parameter int unsigned CORDIC_K = 652032875
) (
    input  logic        Fg_CLK,
    input  logic        RESET,
    input  logic        Start,
    input  logic        Retune,
    input  logic [31:0] Phase,
    input  logic [29:0] Amp,
    input  logic        Run,
    input  logic [15:0] SampleDiv,
    output logic [31:0] init1,
    output logic [31:0] init2,
    output logic        Ready,
    output logic        freqchange,
    output logic        Enable,
    output logic        Busy,
    output logic        Error
);
    typedef enum logic [1:0] {IDLE, ROT, SCALE, ISSUE} state_t;
    localparam logic [4:0] LAST_ITER = 5'(ITER - 1);

    state_t             state;
    logic [4:0]         iter;
    logic signed [33:0] x, y, x_sh, y_sh;
    logic signed [32:0] z, atan_z;
    logic [29:0]        amp_q;
    logic               retune_q;
    logic               phase_bad;
    logic [31:0]        c_sat, s1;
    logic signed [63:0] y_ext, amp_ext, prod;
    logic               ready_set;
    logic [15:0]        div_cnt;

    // Angles in units of 2^-32 turn: round(atan(2^-i) * 2^32 / (2*pi)).
    function automatic logic [31:0] atan_lut(input logic [4:0] i);
        case (i)
            5'd0:  atan_lut = 32'd536870912;
            5'd1:  atan_lut = 32'd316933406;
            5'd2:  atan_lut = 32'd167458907;
            5'd3:  atan_lut = 32'd85004756;
            5'd4:  atan_lut = 32'd42667331;
            5'd5:  atan_lut = 32'd21354465;
            5'd6:  atan_lut = 32'd10679838;
            5'd7:  atan_lut = 32'd5340245;
            5'd8:  atan_lut = 32'd2670163;
            5'd9:  atan_lut = 32'd1335087;
            5'd10: atan_lut = 32'd667544;
            5'd11: atan_lut = 32'd333772;
            5'd12: atan_lut = 32'd166886;
            5'd13: atan_lut = 32'd83443;
            5'd14: atan_lut = 32'd41722;
            5'd15: atan_lut = 32'd20861;
            5'd16: atan_lut = 32'd10430;
            5'd17: atan_lut = 32'd5215;
            5'd18: atan_lut = 32'd2608;
            5'd19: atan_lut = 32'd1304;
            5'd20: atan_lut = 32'd652;
            5'd21: atan_lut = 32'd326;
            5'd22: atan_lut = 32'd163;
            5'd23: atan_lut = 32'd81;
            5'd24: atan_lut = 32'd41;
            5'd25: atan_lut = 32'd20;
            5'd26: atan_lut = 32'd10;
            5'd27: atan_lut = 32'd5;
            5'd28: atan_lut = 32'd3;
            5'd29: atan_lut = 32'd1;
            default: atan_lut = 32'd0;
        endcase
    endfunction

    assign phase_bad = (Phase == 32'd0) || (Phase[31:30] != 2'b00);
    assign x_sh      = x >>> iter;
    assign y_sh      = y >>> iter;
    assign atan_z    = signed'({1'b0, atan_lut(iter)});
    assign y_ext     = 64'(y);
    assign amp_ext   = {34'd0, amp_q};
    assign prod      = y_ext * amp_ext;
    assign s1        = 32'(prod >>> 30);
    assign ready_set = (state == SCALE) && !retune_q;

    always_comb begin
        if (x[33:31] == 3'b000 || x[33:31] == 3'b111) c_sat = x[31:0];
        else                                          c_sat = x[33] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end

    always_ff @(posedge Fg_CLK) begin
        if (RESET) begin
            state      <= IDLE;
            iter       <= '0;
            x          <= '0;
            y          <= '0;
            z          <= '0;
            amp_q      <= '0;
            retune_q   <= 1'b0;
            init1      <= '0;
            init2      <= '0;
            Ready      <= 1'b0;
            freqchange <= 1'b0;
            Busy       <= 1'b0;
            Error      <= 1'b0;
        end else begin
            Ready      <= 1'b0;
            freqchange <= 1'b0;
            Error      <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        if (phase_bad) begin
                            Error <= 1'b1;
                        end else begin
                            amp_q    <= Amp;
                            retune_q <= Retune;
                            x        <= 34'(CORDIC_K);
                            y        <= '0;
                            z        <= signed'({1'b0, Phase});
                            iter     <= '0;
                            Busy     <= 1'b1;
                            state    <= ROT;
                        end
                    end
                end
                ROT: begin
                    if (!z[32]) begin
                        x <= x - y_sh;
                        y <= y + x_sh;
                        z <= z - atan_z;
                    end else begin
                        x <= x + y_sh;
                        y <= y - x_sh;
                        z <= z + atan_z;
                    end
                    iter <= iter + 5'd1;
                    if (iter == LAST_ITER) state <= SCALE;
                end
                // Words and strobe register together so they are first visible in the ISSUE cycle.
                SCALE: begin
                    init2      <= c_sat;
                    init1      <= s1;
                    Ready      <= !retune_q;
                    freqchange <= retune_q;
                    Busy       <= 1'b0;
                    state      <= ISSUE;
                end
                ISSUE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Clearing on the edge that raises Ready puts the first Enable exactly SampleDiv clocks after it.
    always_ff @(posedge Fg_CLK) begin
        if (RESET) begin
            div_cnt <= '0;
            Enable  <= 1'b0;
        end else if (!Run || SampleDiv == 16'd0 || ready_set) begin
            div_cnt <= '0;
            Enable  <= 1'b0;
        end else if (div_cnt == SampleDiv - 16'd1) begin
            div_cnt <= '0;
            Enable  <= 1'b1;
        end else begin
            div_cnt <= div_cnt + 16'd1;
            Enable  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_osc_coef_gen.sv
// Randomized bench for osc_coef_gen: load words against real-valued trig, strobe timing and Enable cadence.
module tb_osc_coef_gen;
    localparam real PI       = 3.14159265358979323846;
    localparam int  STROBE_K = 32;

    logic        Fg_CLK = 1'b0;
    logic        RESET, Start, Retune, Run;
    logic [31:0] Phase;
    logic [29:0] Amp;
    logic [15:0] SampleDiv;
    logic [31:0] init1, init2;
    logic        Ready, freqchange, Enable, Busy, Error;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int ready_cyc = -1;
    int en_q[$];

    osc_coef_gen dut (
        .Fg_CLK(Fg_CLK), .RESET(RESET), .Start(Start), .Retune(Retune),
        .Phase(Phase), .Amp(Amp), .Run(Run), .SampleDiv(SampleDiv),
        .init1(init1), .init2(init2), .Ready(Ready), .freqchange(freqchange),
        .Enable(Enable), .Busy(Busy), .Error(Error)
    );

    always #5 Fg_CLK = ~Fg_CLK;

    // Timestamp Enable pulses and Ready strobes just after each rising edge.
    always @(posedge Fg_CLK) begin
        #1;
        cyc++;
        if (Enable) en_q.push_back(cyc);
        if (Ready) ready_cyc = cyc;
    end

    task automatic check_val(input string tag, input longint obs, input longint exp, input longint tol = 0);
        longint diff;
        n_chk++;
        diff = obs - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic tick();
        @(posedge Fg_CLK);
        @(negedge Fg_CLK);
    endtask

    function automatic longint rnd(input real v);
        return longint'($floor(v + 0.5));
    endfunction

    task automatic run_coef(input string tag, input logic [31:0] ph, input logic [29:0] am,
                            input logic rt, input int second_at);
        logic [31:0] i1_pre, i2_pre, i1_got, i2_got;
        int     busy_n, busy_first, strobe_n, strobe_at, wrong_n, err_n, early_chg, late_chg;
        real    b;
        longint e1, e2;
        i1_pre = init1; i2_pre = init2; i1_got = '0; i2_got = '0;
        busy_n = 0; busy_first = -1; strobe_n = 0; strobe_at = -1;
        wrong_n = 0; err_n = 0; early_chg = 0; late_chg = 0;
        b  = real'(ph) * 2.0 * PI / 4294967296.0;
        e2 = rnd(2.0 * $cos(b) * 536870912.0);
        e1 = rnd(real'(am) * $sin(b));
        Phase = ph; Amp = am; Retune = rt; Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int k = 1; k <= 48; k++) begin
            if (Busy) begin
                busy_n++;
                if (busy_first < 0) busy_first = k;
            end
            if (Error) err_n++;
            if (rt ? freqchange : Ready) begin strobe_n++; strobe_at = k; end
            if (rt ? Ready : freqchange) wrong_n++;
            if (k < STROBE_K && (init1 != i1_pre || init2 != i2_pre)) early_chg++;
            if (k == STROBE_K) begin i1_got = init1; i2_got = init2; end
            if (k > STROBE_K && (init1 != i1_got || init2 != i2_got)) late_chg++;
            Start = (k == second_at);
            if (k == second_at) begin
                Phase  = 32'($urandom_range(1, 32'h3FFF_FFFF));
                Retune = ~rt;
            end
            tick();
        end
        Start = 1'b0;
        check_val({tag, "_busy_first"}, longint'(busy_first), 1);
        check_val({tag, "_busy_len"},   longint'(busy_n), 31);
        check_val({tag, "_strobe_n"},   longint'(strobe_n), 1);
        check_val({tag, "_strobe_at"},  longint'(strobe_at), STROBE_K);
        check_val({tag, "_wrong_strb"}, longint'(wrong_n), 0);
        check_val({tag, "_error"},      longint'(err_n), 0);
        check_val({tag, "_early_chg"},  longint'(early_chg), 0);
        check_val({tag, "_late_chg"},   longint'(late_chg), 0);
        check_val({tag, "_init2"}, longint'($signed(i2_got)), e2, 64);
        check_val({tag, "_init1"}, longint'($signed(i1_got)), e1, 64 + (longint'(am) >> 24));
    endtask

    task automatic run_bad(input string tag, input logic [31:0] ph);
        logic [31:0] i1_pre, i2_pre;
        int err_first, err_more, busy_n, strobe_n, chg_n;
        i1_pre = init1; i2_pre = init2;
        err_first = 0; err_more = 0; busy_n = 0; strobe_n = 0; chg_n = 0;
        Phase = ph; Amp = 30'($urandom); Retune = 1'b0; Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int k = 1; k <= 36; k++) begin
            if (k == 1) err_first = int'(Error);
            else if (Error) err_more++;
            if (Busy) busy_n++;
            if (Ready || freqchange) strobe_n++;
            if (init1 != i1_pre || init2 != i2_pre) chg_n++;
            tick();
        end
        check_val({tag, "_err_pulse"}, longint'(err_first), 1);
        check_val({tag, "_err_extra"}, longint'(err_more), 0);
        check_val({tag, "_busy"},      longint'(busy_n), 0);
        check_val({tag, "_strobe"},    longint'(strobe_n), 0);
        check_val({tag, "_init_chg"},  longint'(chg_n), 0);
    endtask

    task automatic chk_cadence(input string tag, input int div, input int n_exp);
        int bad;
        bad = 0;
        for (int i = 1; i < en_q.size(); i++)
            if (en_q[i] - en_q[i-1] != div) bad++;
        check_val({tag, "_gaps"}, longint'(bad), 0);
        if (n_exp >= 0) check_val({tag, "_count"}, longint'(en_q.size()), longint'(n_exp));
    endtask

    initial begin
        int first_after, div, strobe_n, busy_n;
        RESET = 1'b1; Start = 1'b0; Retune = 1'b0; Run = 1'b0;
        Phase = '0; Amp = '0; SampleDiv = '0;
        repeat (3) tick();
        check_val("rst_init1", longint'(init1), 0);
        check_val("rst_init2", longint'(init2), 0);
        check_val("rst_flags", longint'({Ready, freqchange, Enable, Busy, Error}), 0);
        RESET = 1'b0;
        tick();

        run_coef("pi8", 32'h1000_0000, 30'h2000_0000, 1'b0, 0);
        run_coef("pi2", 32'h3FFF_FFFF, 30'h1FFF_FFFF, 1'b0, 0);
        run_bad("ph0", 32'd0);
        run_bad("ph_2p30", 32'h4000_0000);
        run_coef("retune", 32'h0800_0000, 30'($urandom), 1'b1, 10);
        for (int r = 0; r < 6; r++)
            run_coef("rnd", 32'($urandom_range(1, 32'h3FFF_FFFF)), 30'($urandom),
                     1'($urandom_range(0, 1)), (r % 2 == 0) ? STROBE_K : 5);
        run_bad("rnd_bad", 32'($urandom_range(32'h4000_0000, 32'hFFFF_FFFF)));

        Run = 1'b1; SampleDiv = 16'd4;
        tick();
        en_q.delete();
        repeat (20) tick();
        chk_cadence("en4", 4, 5);

        en_q.delete();
        run_coef("load_en", 32'($urandom_range(1, 32'h3FFF_FFFF)), 30'($urandom), 1'b0, 0);
        first_after = -1;
        foreach (en_q[i]) if (first_after < 0 && en_q[i] > ready_cyc) first_after = en_q[i];
        check_val("en_after_ready", longint'(first_after - ready_cyc), 4);

        en_q.delete();
        run_coef("retune_en", 32'($urandom_range(1, 32'h3FFF_FFFF)), 30'($urandom), 1'b1, 0);
        chk_cadence("en_fc", 4, -1);

        Run = 1'b0; tick();
        SampleDiv = 16'd1; Run = 1'b1; tick();
        en_q.delete();
        repeat (10) tick();
        chk_cadence("en1", 1, 10);

        SampleDiv = 16'd0; tick();
        en_q.delete();
        repeat (20) tick();
        check_val("en0_count", longint'(en_q.size()), 0);

        for (int r = 0; r < 3; r++) begin
            div = $urandom_range(2, 9);
            Run = 1'b0; tick();
            SampleDiv = 16'(div); Run = 1'b1; tick();
            en_q.delete();
            repeat (4 * div) tick();
            chk_cadence("en_rnd", div, 4);
        end

        // Abort mid-ROT with SampleDiv=1 so Enable would otherwise be high.
        SampleDiv = 16'd1;
        Phase = 32'h2000_0000; Amp = 30'h2000_0000; Retune = 1'b0; Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (14) tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check_val("abort_init1", longint'(init1), 0);
        check_val("abort_init2", longint'(init2), 0);
        check_val("abort_flags", longint'({Ready, freqchange, Enable, Busy, Error}), 0);
        strobe_n = 0; busy_n = 0;
        for (int k = 0; k < 40; k++) begin
            if (Ready || freqchange) strobe_n++;
            if (Busy) busy_n++;
            tick();
        end
        check_val("abort_strobe", longint'(strobe_n), 0);
        check_val("abort_busy", longint'(busy_n), 0);
        Run = 1'b0;
        run_coef("after_abort", 32'($urandom_range(1, 32'h3FFF_FFFF)), 30'($urandom), 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
